// File: rtl/i2c_slave_regfile_pkg.sv
// i2c_slave_regfile_pkg: FSM state encoding and default sizing for the I2C slave register file.
package i2c_regfile_pkg;

    localparam int REG_NUM_DEF = 16;
    localparam int PTR_W_DEF   = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GET_PTR = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;

    function automatic logic is_rd_state(input logic [2:0] s);
        return (s == ST_RD_DATA) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// i2c_slave_regfile_if: byte-level I2C slave handshake, status and local host port of the register file.
interface i2c_slave_regfile_if import i2c_regfile_pkg::*; #(
    parameter int PTR_W = PTR_W_DEF
);
    logic             en;
    logic             rd_reg_full;
    logic [7:0]       byte_rd;
    logic             rd_clr;
    logic             wr_reg_empty;
    logic [7:0]       byte_wr;
    logic             wr_rdy;
    logic             addr_match;
    logic             trans_dir;
    logic             trans_stop;
    logic             bus_err;
    logic [PTR_W-1:0] host_addr;
    logic [7:0]       host_wdata;
    logic             host_we;
    logic [7:0]       host_rdata;
    logic             wr_evt;
    logic [PTR_W-1:0] wr_evt_addr;
    logic [PTR_W-1:0] ptr;

    modport slave (
        input  en, rd_reg_full, byte_rd, wr_reg_empty, addr_match, trans_dir, trans_stop, bus_err,
        input  host_addr, host_wdata, host_we,
        output rd_clr, byte_wr, wr_rdy, host_rdata, wr_evt, wr_evt_addr, ptr
    );

    modport master (
        output en, rd_reg_full, byte_rd, wr_reg_empty, addr_match, trans_dir, trans_stop, bus_err,
        output host_addr, host_wdata, host_we,
        input  rd_clr, byte_wr, wr_rdy, host_rdata, wr_evt, wr_evt_addr, ptr
    );

endinterface

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: register file behind a byte-level I2C slave; first written byte sets the pointer,
// later bytes write/read consecutive registers with auto-increment, plus a local host port.
module i2c_slave_regfile import i2c_regfile_pkg::*; #(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int PTR_W   = PTR_W_DEF
) (
    input logic          clk,
    input logic          rst,
    i2c_slave_regfile_if.slave bus
);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_wr_evt_addr;
    logic [7:0]       r_regs [REG_NUM];
    logic [7:0]       r_byte_wr;
    logic [7:0]       r_host_rdata;
    logic             r_am_d;
    logic             r_rd_clr;
    logic             r_wr_rdy;
    logic             r_wr_evt;
    logic             w_start;
    logic             w_stop;
    logic             w_busy;
    logic             w_take;
    logic             w_set_ptr;
    logic             w_wr;
    logic             w_send;
    logic             w_ret;

    // w_take is the only source of rd_clr; masking with r_rd_clr skips the slave's release cycle
    always_comb begin
        w_start   = r_am_d & ~bus.addr_match;
        w_stop    = bus.trans_stop | bus.bus_err;
        w_busy    = ~bus.en | w_stop | w_start;
        w_take    = ~w_busy & bus.rd_reg_full & ~r_rd_clr;
        w_set_ptr = w_take & (r_state == ST_GET_PTR);
        w_wr      = w_take & (r_state == ST_WR_DATA);
        w_send    = ~w_busy & bus.wr_reg_empty & (r_state == ST_RD_DATA);
        w_ret     = bus.en & w_stop & ~bus.wr_reg_empty & is_rd_state(r_state);
        w_next    = (~bus.en | w_stop)       ? ST_IDLE :
                    w_start                  ? (bus.trans_dir ? ST_RD_DATA : ST_GET_PTR) :
                    w_set_ptr                ? ST_WR_DATA :
                    w_send                   ? ST_RD_WAIT :
                    (r_state == ST_RD_WAIT)  ? ST_RD_DATA : r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_wr_evt_addr <= '0;
            r_byte_wr     <= '0;
            r_host_rdata  <= '0;
            r_am_d        <= 1'b0;
            r_rd_clr      <= 1'b0;
            r_wr_rdy      <= 1'b0;
            r_wr_evt      <= 1'b0;
            for (int i = 0; i < REG_NUM; i++)
                r_regs[i] <= '0;
        end else begin
            r_state      <= w_next;
            r_am_d       <= bus.addr_match;
            r_rd_clr     <= w_take;
            r_wr_rdy     <= w_send;
            r_wr_evt     <= w_wr;
            r_host_rdata <= r_regs[bus.host_addr];
            // the I2C write is issued last so it wins a same-index collision with the host
            if (bus.host_we)
                r_regs[bus.host_addr] <= bus.host_wdata;
            if (w_wr) begin
                r_regs[r_ptr] <= bus.byte_rd;
                r_wr_evt_addr <= r_ptr;
            end
            if (w_send)
                r_byte_wr <= r_regs[r_ptr];
            r_ptr <= w_set_ptr       ? bus.byte_rd[PTR_W-1:0] :
                     (w_wr | w_send) ? r_ptr + 1'b1 :
                     w_ret           ? r_ptr - 1'b1 : r_ptr;
        end
    end

    assign bus.rd_clr      = r_rd_clr;
    assign bus.wr_rdy      = r_wr_rdy;
    assign bus.wr_evt      = r_wr_evt;
    assign bus.byte_wr     = r_byte_wr;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.wr_evt_addr = r_wr_evt_addr;
    assign bus.ptr         = r_ptr;

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 16, giving the register count (power of two, 2..256).
REQ-002 The block SHALL have parameter PTR_W, default 4, equal to log2(REG_NUM).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: block enable, tied to the slave's slave_en.
REQ-006 The block SHALL have port rd_reg_full, input, 1 bit: the slave holds a received byte.
REQ-007 The block SHALL have port byte_rd, input, 8 bits: the received byte from the slave.
REQ-008 The block SHALL have port rd_clr, output, 1 bit: one-cycle pulse that releases the received byte.
REQ-009 The block SHALL have port wr_reg_empty, input, 1 bit: the slave transmit register is empty.
REQ-010 The block SHALL have port byte_wr, output, 8 bits: the byte to transmit.
REQ-011 The block SHALL have port wr_rdy, output, 1 bit: one-cycle pulse that loads byte_wr into the slave.
REQ-012 The block SHALL have ports addr_match, trans_dir, trans_stop and bus_err, each input, 1 bit: status from the slave.
REQ-013 The block SHALL have ports host_addr (input, PTR_W), host_wdata (input, 8), host_we (input, 1) and host_rdata (output, 8): the local register access port.
REQ-014 The block SHALL have ports wr_evt (output, 1) and wr_evt_addr (output, PTR_W): a one-cycle pulse for each register written over I2C, with its index.
REQ-015 The block SHALL have port ptr (output, PTR_W): the current register pointer.

Function
REQ-016 The FSM SHALL have the states IDLE, GET_PTR, WR_DATA, RD_DATA, RD_WAIT.
REQ-017 A session start SHALL be the cycle where addr_match was 1 in the previous cycle and is 0 now; trans_dir is sampled in that cycle.
REQ-018 On a session start from any state, the FSM SHALL go to GET_PTR if trans_dir=0, and to RD_DATA if trans_dir=1. This also covers a repeated start.
REQ-019 In GET_PTR, when rd_reg_full=1: ptr <= byte_rd[PTR_W-1:0] (upper bits ignored), rd_clr pulses, and the FSM goes to WR_DATA.
REQ-020 In WR_DATA, when rd_reg_full=1:
  - regs[ptr] <= byte_rd;
  - wr_evt pulses, with wr_evt_addr = old ptr;
  - rd_clr pulses;
  - ptr increments modulo REG_NUM (REG_NUM-1 wraps to 0).
REQ-021 rd_clr SHALL never be asserted in two consecutive cycles; the cycle after a rd_clr SHALL ignore rd_reg_full.
REQ-022 In RD_DATA, when wr_reg_empty=1: byte_wr <= regs[ptr], wr_rdy pulses, ptr increments modulo REG_NUM, and the FSM goes to RD_WAIT.
REQ-023 RD_WAIT SHALL last exactly one cycle and then return to RD_DATA. This absorbs the slave's one-cycle wr_reg_empty update latency.
REQ-024 If trans_stop or bus_err is 1 in any state, the FSM SHALL go to IDLE; this has priority over every other transition except reset.
REQ-025 If trans_stop or bus_err is 1 in RD_DATA or RD_WAIT while wr_reg_empty=0, ptr SHALL decrement by 1 modulo REG_NUM, returning the unsent prefetched byte.
REQ-026 In IDLE, and in RD_DATA/RD_WAIT, rd_reg_full=1 SHALL produce a rd_clr pulse and the byte SHALL be discarded (subject to REQ-021).
REQ-027 ptr SHALL persist across sessions; a read session SHALL start at the current ptr.
REQ-028 host_we=1 SHALL write host_wdata to regs[host_addr] at the next edge.
REQ-029 If an I2C write (REQ-020) targets the same index in the same cycle as host_we, the I2C write SHALL win and the host write SHALL be dropped.
REQ-030 host_rdata SHALL be registered: it equals regs[host_addr] one cycle after the address is presented, and reflects writes committed before that edge.
REQ-031 en=0 SHALL force the FSM to IDLE and deassert rd_clr, wr_rdy and wr_evt; regs and ptr SHALL be retained.

Reset
REQ-032 rst=1 SHALL asynchronously force:
  - the FSM to IDLE;
  - all regs, ptr, byte_wr, host_rdata and wr_evt_addr to 0;
  - rd_clr, wr_rdy and wr_evt to 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer, with no partial register write.

Structure
REQ-034 The package i2c_regfile_pkg SHALL hold the FSM state encoding and the default REG_NUM/PTR_W constants.
REQ-035 The register array SHALL be inline; no sub-module is required.

Verification
REQ-036 Test: write session with bytes 0x03, 0xA5, 0x5A, then stop -> regs[3]=0xA5, regs[4]=0x5A, ptr=5, and wr_evt pulses at addresses 3 and 4.
REQ-037 Test: ptr=15, write two data bytes 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22, ptr=1 (wrap).
REQ-038 Test: regs[2]=0x77, regs[3]=0x88, repeated-start read of 2 bytes with the master NACKing the 2nd byte, then stop -> bytes 0x77, 0x88 transmitted; the prefetch of regs[4] is returned and ptr=4.
REQ-039 Test: host_we to index 6 with 0xFF in the same cycle as an I2C write of 0x01 to index 6 -> regs[6]=0x01.
REQ-040 Test: bus_err during WR_DATA -> FSM in IDLE the next cycle; a following rd_reg_full is discarded with a rd_clr pulse.
REQ-041 Test: rst pulsed mid-read -> all outputs 0 and ptr=0 immediately, asynchronous to clk.
